wb_master_port: RTL and testbench

//  Wishbone B4 classic initiator that turns single-beat user-logic commands into bus cycles on a downstream

---
 rtl/wbm_pkg.sv | 16 +
 rtl/wbm_timeout_ctr.sv | 39 +++
 rtl/wb_master_port.sv | 133 +++++++++++++
 tb/tb_wb_master_port.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// rtl/wbm_pkg.sv - shared types for the Wishbone classic initiator port
package wbm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } wbm_state_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_BUSERR  = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_err_e;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// rtl/wbm_timeout_ctr.sv - bus-cycle watchdog, expires in the TIMEOUT-th enabled cycle
module wbm_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_ctr
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            // cnt holds the number of enabled cycles already elapsed, so the
            // current cycle is number cnt+1; saturate so it can never wrap.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && (cnt != LAST)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expire = enable && !clear && (cnt == LAST);
        end else begin : g_none
            logic unused_tie;
            assign unused_tie = ^{clk, resetn, clear, enable};
            assign expire     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - single-outstanding Wishbone B4 classic initiator with buffered response
module wb_master_port
    import wbm_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic [1:0]      rsp_err,

    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    wbm_state_e state, state_d;
    rsp_err_e   term_code;
    logic       accept;
    logic       finish;
    logic       expire;

    wbm_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (wb_clk_i),
        .resetn (wb_rst_ni),
        .clear  (state != BUS),
        .enable (state == BUS),
        .expire (expire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Termination priority: err over ack, and any slave response over timeout.
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        finish    = 1'b0;
        term_code = RSP_OK;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_err_i) begin
                    finish    = 1'b1;
                    term_code = RSP_BUSERR;
                end else if (wbm_ack_i) begin
                    finish    = 1'b1;
                    term_code = RSP_OK;
                end else if (expire) begin
                    finish    = 1'b1;
                    term_code = RSP_TIMEOUT;
                end
                if (finish) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= RSP_OK;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            cmd_ready <= (state_d == IDLE);
            if (accept) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
            end
            if (finish) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= term_code;
                rsp_dat   <= ((term_code == RSP_OK) && !wbm_we_o) ? wbm_dat_i : '0;
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_dat   <= '0;
                rsp_err   <= RSP_OK;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_port.sv
// tb/tb_wb_master_port.sv - randomized self-checking bench for wb_master_port
module tb_wb_master_port;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          wb_rst_ni;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [3:0]    cmd_sel;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_err;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;
    logic          wbm_ack_i, wbm_err_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_master_port #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (wb_rst_ni),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave. waits = cycles before the response.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int waits, input int kind,
                           input int rsp_delay, input logic hold_valid);
        logic [31:0] rd, exp_dat;
        logic [1:0]  exp_err;
        int          exp_len, n, guard;
        bit          times_out;

        guard = 0;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        check("cmd_ready_idle", cmd_ready, 1'b1);

        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        step();
        check("accept_cyc_stb_rdy", {wbm_cyc_o, wbm_stb_o, cmd_ready}, 3'b110);

        // Later command changes must not reach the bus.
        cmd_valid = hold_valid;
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);

        rd        = $urandom;
        times_out = (kind == 3) || (waits + 1 > TMO);
        exp_len   = times_out ? TMO : waits + 1;
        if (times_out) begin
            exp_err = 2'b10;
            exp_dat = '0;
        end else if (kind == 0) begin
            exp_err = 2'b00;
            exp_dat = we ? 32'h0 : rd;
        end else begin
            exp_err = 2'b01;
            exp_dat = '0;
        end

        n = 0;
        while (wbm_cyc_o && n < 40) begin
            n++;
            check("bus_hold", {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid},
                  {1'b1, we, sel, adr, dat, 1'b0});
            if (kind != 3 && n == waits + 1) begin
                wbm_ack_i = (kind != 1);
                wbm_err_i = (kind != 0);
                wbm_dat_i = rd;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            step();
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        check("bus_len", n, exp_len);

        for (int i = 0; i <= rsp_delay; i++) begin
            check("rsp_hold", {rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc_o, wbm_stb_o},
                  {1'b1, exp_err, exp_dat, 3'b000});
            rsp_ready = (i == rsp_delay);
            wbm_ack_i = 1'($urandom);
            wbm_err_i = 1'($urandom);
            wbm_dat_i = $urandom;
            step();
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_done", {rsp_valid, cmd_ready, wbm_cyc_o}, 3'b010);
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        step();
        step();
        check("reset_state",
              {cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o,
               wbm_sel_o, wbm_adr_o, wbm_dat_o},
              {1'b1, 1'b0, 32'h0, 2'b00, 3'b000, 4'h0, 32'h0, 32'h0});
        wb_rst_ni = 1'b1;
        step();

        run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0);
        run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 0, 0, 1'b0);
        run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 2, 0, 1'b0);
        run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 3, 0, 1'b0);
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, TMO - 1, 0, 0, 1'b0);
        run_txn(1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'h3, 2, 1, 5, 1'b1);
        run_txn(1'b0, 32'h3000_0018, 32'h0, 4'hC, 0, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, TMO + 2), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom));
        end

        // Reset while a bus cycle is outstanding.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0020;
        cmd_sel   = 4'hF;
        step();
        cmd_valid = 1'b0;
        step();
        wb_rst_ni = 1'b0;
        step();
        check("reset_mid_bus", {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}, 4'b0001);
        wb_rst_ni = 1'b1;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_FFFF;
        step();
        wbm_ack_i = 1'b0;
        check("stray_ack_idle", {wbm_cyc_o, rsp_valid, cmd_ready}, 3'b001);
        run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1, 0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
